// File: rtl/clip_pkg.sv
// Shared types and constants for the multichannel clip/distortion stage.
package clip_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_HARD   = 2'd1,
      MODE_ASYM   = 2'd2,
      MODE_SOFT   = 2'd3
   } clip_mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GAIN   = 2'd1,
      CLIP   = 2'd2,
      OUTPUT = 2'd3
   } clip_state_t;

   typedef enum logic [1:0] {
      SEL_MODE    = 2'd0,
      SEL_GAIN    = 2'd1,
      SEL_THR_POS = 2'd2,
      SEL_THR_NEG = 2'd3
   } cfg_sel_t;

   // Gain is fixed point with this many fractional bits (0x10 == 1.0).
   localparam int unsigned GAIN_FRAC = 4;
   localparam int unsigned COUNT_W   = 16;

endpackage

// File: rtl/multi_clip_effect_if.sv
// Sample stream handshake between upstream, the clip stage and downstream.
interface multi_clip_effect_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CH_W       = 1
) ();

   logic signed [DATA_WIDTH-1:0] i_data;
   logic        [CH_W-1:0]       i_ch;
   logic                         i_valid;
   logic                         o_ready;
   logic signed [DATA_WIDTH-1:0] o_data;
   logic        [CH_W-1:0]       o_ch;
   logic                         o_valid;
   logic                         i_ready;

   // Driver side: supplies input samples and the downstream ready.
   modport master (
      output i_data, i_ch, i_valid, i_ready,
      input  o_ready, o_data, o_ch, o_valid
   );

   // Clip stage side.
   modport slave (
      input  i_data, i_ch, i_valid, i_ready,
      output o_ready, o_data, o_ch, o_valid
   );

endinterface

// File: rtl/clip_core.sv
// Combinational clip kernel: bypass, hard, asymmetric hard and soft-knee.
// Magnitudes are handled at DATA_WIDTH+1 bits so the most negative input
// has a representable absolute value.
module clip_core
   import clip_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic signed [DATA_WIDTH-1:0] x,
   input  clip_mode_t                   mode,
   input  logic        [DATA_WIDTH-2:0] thr_pos,
   input  logic        [DATA_WIDTH-2:0] thr_neg,
   output logic signed [DATA_WIDTH-1:0] y,
   output logic                         clipped
);

   localparam int W = DATA_WIDTH + 1;

   logic                  neg;
   logic [W-1:0]          xe;
   logic [W-1:0]          ax;
   logic [W-1:0]          tp;
   logic [W-1:0]          tn;
   logic [W-1:0]          knee;
   logic [W-1:0]          lim;
   logic [W-1:0]          mag;
   logic [DATA_WIDTH-1:0] sgn;

   // Limit |x| according to the mode, then restore the sign.
   always_comb begin
      neg  = x[DATA_WIDTH-1];
      xe   = {x[DATA_WIDTH-1], x};
      ax   = neg ? (~xe + W'(1)) : xe;
      tp   = W'(thr_pos);
      tn   = W'(thr_neg);
      knee = tp >> 1;
      lim  = tp;
      mag  = ax;
      case (mode)
         MODE_HARD, MODE_ASYM: begin
            lim = (neg && (mode == MODE_ASYM)) ? tn : tp;
            if (ax > lim) mag = lim;
         end
         MODE_SOFT: begin
            if (ax > knee) begin
               mag = knee + ((ax - knee) >> 1);
               if (mag > tp) mag = tp;
            end
         end
         default: ;
      endcase
      sgn     = neg ? (~mag[DATA_WIDTH-1:0] + DATA_WIDTH'(1)) : mag[DATA_WIDTH-1:0];
      y       = (mode == MODE_BYPASS) ? x : $signed(sgn);
      clipped = (mode != MODE_BYPASS) && (y != x);
   end

endmodule

// File: rtl/multi_clip_effect.sv
// Multichannel pre-gain + clip stage with per-channel config registers.
// Optional feature macro: CLIP_COUNT_EN enables the saturating clip event
// counter on o_clip_count (otherwise it is tied to zero).
module multi_clip_effect
   import clip_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int CHANNELS   = 2,
   parameter  int GAIN_WIDTH = 8,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   multi_clip_effect_if.slave     bus,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [1:0]             cfg_sel,
   input  logic [DATA_WIDTH-1:0]  cfg_data,
   output logic [COUNT_W-1:0]     o_clip_count
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);
   localparam logic signed [PW-1:0] SAT_MAX = {{(GAIN_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(GAIN_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1 << GAIN_FRAC);

   clip_mode_t                cfg_mode [CHANNELS];
   logic [GAIN_WIDTH-1:0]     cfg_gain [CHANNELS];
   logic [DATA_WIDTH-2:0]     cfg_tp   [CHANNELS];
   logic [DATA_WIDTH-2:0]     cfg_tn   [CHANNELS];

   clip_state_t               state;
   logic signed [DATA_WIDTH-1:0] cap_data;
   logic [CH_W-1:0]           cap_ch;
   clip_mode_t                snap_mode;
   logic [GAIN_WIDTH-1:0]     snap_gain;
   logic [DATA_WIDTH-2:0]     snap_tp;
   logic [DATA_WIDTH-2:0]     snap_tn;
   logic signed [DATA_WIDTH-1:0] gained;

   logic                      in_ch_ok;
   logic                      cfg_ch_ok;
   logic [CH_W-1:0]           rd_idx;
   logic signed [PW-1:0]      prod;
   logic signed [PW-1:0]      prod_sh;
   logic signed [DATA_WIDTH-1:0] gain_sat;
   logic signed [DATA_WIDTH-1:0] core_y;
   logic                      core_clipped;
   logic                      count_clear;
   logic                      unused_cfg_msb;

   assign unused_cfg_msb = cfg_data[DATA_WIDTH-1];

   // Out-of-range input tags read channel 0 settings; out-of-range config targets are dropped.
   always_comb begin
      in_ch_ok  = ({1'b0, bus.i_ch} < CH_LIMIT);
      cfg_ch_ok = ({1'b0, cfg_ch} < CH_LIMIT);
      rd_idx    = in_ch_ok ? bus.i_ch : '0;
   end

`ifdef CLIP_COUNT_EN
   assign count_clear = cfg_we && (cfg_sel == SEL_THR_NEG) && (&cfg_ch);
`else
   assign count_clear = 1'b0;
`endif

   // Per-channel configuration registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cfg_mode[i] <= MODE_BYPASS;
            cfg_gain[i] <= GAIN_ONE;
            cfg_tp[i]   <= '1;
            cfg_tn[i]   <= '1;
         end
      end else if (cfg_we && cfg_ch_ok) begin
         case (cfg_sel_t'(cfg_sel))
            SEL_MODE:    cfg_mode[cfg_ch] <= clip_mode_t'(cfg_data[1:0]);
            SEL_GAIN:    cfg_gain[cfg_ch] <= cfg_data[GAIN_WIDTH-1:0];
            SEL_THR_POS: cfg_tp[cfg_ch]   <= cfg_data[DATA_WIDTH-2:0];
            SEL_THR_NEG: if (!count_clear) cfg_tn[cfg_ch] <= cfg_data[DATA_WIDTH-2:0];
            default: ;
         endcase
      end
   end

   // Pre-gain: signed sample times unsigned gain, drop fraction, saturate.
   always_comb begin
      prod    = PW'(cap_data) * PW'($signed({1'b0, snap_gain}));
      prod_sh = prod >>> GAIN_FRAC;
      if (prod_sh > SAT_MAX)      gain_sat = SAT_MAX[DATA_WIDTH-1:0];
      else if (prod_sh < SAT_MIN) gain_sat = SAT_MIN[DATA_WIDTH-1:0];
      else                        gain_sat = prod_sh[DATA_WIDTH-1:0];
   end

   clip_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_clip_core (
      .x       (gained),
      .mode    (snap_mode),
      .thr_pos (snap_tp),
      .thr_neg (snap_tn),
      .y       (core_y),
      .clipped (core_clipped)
   );

   // Transaction FSM: accept, gain, clip, hold output until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bus.o_ready <= 1'b1;
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
         bus.o_ch    <= '0;
         cap_data    <= '0;
         cap_ch      <= '0;
         snap_mode   <= MODE_BYPASS;
         snap_gain   <= GAIN_ONE;
         snap_tp     <= '1;
         snap_tn     <= '1;
         gained      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid && bus.o_ready) begin
                  cap_data    <= bus.i_data;
                  cap_ch      <= bus.i_ch;
                  snap_mode   <= cfg_mode[rd_idx];
                  snap_gain   <= cfg_gain[rd_idx];
                  snap_tp     <= cfg_tp[rd_idx];
                  snap_tn     <= cfg_tn[rd_idx];
                  bus.o_ready <= 1'b0;
                  state       <= GAIN;
               end
            end
            GAIN: begin
               gained <= gain_sat;
               state  <= CLIP;
            end
            CLIP: begin
               bus.o_data  <= core_y;
               bus.o_ch    <= cap_ch;
               bus.o_valid <= 1'b1;
               state       <= OUTPUT;
            end
            OUTPUT: begin
               if (bus.i_ready) begin
                  bus.o_valid <= 1'b0;
                  bus.o_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CLIP_COUNT_EN
   // Saturating clip event counter; the reserved thr_neg write clears it.
   always_ff @(posedge clk) begin
      if (reset || count_clear) begin
         o_clip_count <= '0;
      end else if ((state == CLIP) && core_clipped && (o_clip_count != '1)) begin
         o_clip_count <= o_clip_count + COUNT_W'(1);
      end
   end
`else
   logic unused_clipped;
   assign unused_clipped = core_clipped ^ count_clear;
   assign o_clip_count   = '0;
`endif

endmodule
